// File: rtl/pc_fetch_unit_pkg.sv
// Shared fetch-stage types and constants: next-PC source encoding, NOP word, jump target helper.
package pc_fetch_unit_pkg;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    NPC_SEQ    = 2'd0,
    NPC_JUMP   = 2'd1,
    NPC_BRANCH = 2'd2
  } npc_sel_e;

  // J-type target keeps the 256MB region of the delay-free successor PC.
  function automatic logic [31:0] jump_addr(input logic [3:0] region, input logic [25:0] target);
    return {region, target, 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if_id_reg.sv
// IF/ID pipeline register: load, flush (valid cleared, NOP inserted), kill (valid only), else hold.
module if_id_reg
  import pc_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              flush,
  input  logic              kill,
  input  logic [31:0]       instr_in,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [ADDR_W-1:0] pc_plus4_in,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr    <= NOP;
      pc       <= '0;
      pc_plus4 <= '0;
      valid    <= 1'b0;
    end else if (kill) begin
      valid <= 1'b0;
    end else if (flush) begin
      // pc/pc_plus4 are meaningless once valid drops, so they simply hold.
      instr <= NOP;
      valid <= 1'b0;
    end else if (load) begin
      instr    <= instr_in;
      pc       <= pc_in;
      pc_plus4 <= pc_plus4_in;
      valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: PC register, next-PC selection (sequential/jump/branch), range check with sticky fault,
// and the IF/ID register fed from a zero-latency instruction memory.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                IMEM_DEPTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [31:0]       branch_offset,
  input  logic              jump,
  input  logic [25:0]       jump_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_instr,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_pc_plus4,
  output logic              if_valid,
  output logic              addr_fault
);

  localparam logic [ADDR_W-1:0] PC_LIMIT = ADDR_W'(IMEM_DEPTH * 4);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_seq;
  logic [ADDR_W-1:0] next_pc;
  logic              redirect;
  logic              advance;
  logic              out_of_range;
  npc_sel_e          npc_sel;

  assign imem_addr = pc;
  assign pc_seq    = pc + ADDR_W'(4);
  assign redirect  = if_valid & (jump | branch_taken);
  assign advance   = ~addr_fault & ~stall;

  always_comb begin
    npc_sel = NPC_SEQ;
    if (redirect) begin
      npc_sel = jump ? NPC_JUMP : NPC_BRANCH;
    end
  end

  always_comb begin
    next_pc = pc_seq;
    case (npc_sel)
      NPC_JUMP:   next_pc = ADDR_W'(jump_addr(if_pc_plus4[ADDR_W-1:ADDR_W-4], jump_target));
      NPC_BRANCH: next_pc = if_pc_plus4 + ADDR_W'(branch_offset << 2);
      default:    next_pc = pc_seq;
    endcase
  end

  assign out_of_range = (next_pc >= PC_LIMIT);

  // An out-of-range target freezes the PC for good; IF/ID still takes this edge's update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc         <= RESET_PC;
      addr_fault <= 1'b0;
    end else if (advance) begin
      if (out_of_range) begin
        addr_fault <= 1'b1;
      end else begin
        pc <= next_pc;
      end
    end
  end

  if_id_reg #(
    .ADDR_W (ADDR_W)
  ) u_if_id (
    .clk         (clk),
    .rst         (reset),
    .load        (advance & ~redirect),
    .flush       (advance & redirect),
    .kill        (addr_fault),
    .instr_in    (imem_instr),
    .pc_in       (pc),
    .pc_plus4_in (pc_seq),
    .instr       (if_instr),
    .pc          (if_pc),
    .pc_plus4    (if_pc_plus4),
    .valid       (if_valid)
  );

endmodule
